cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Arbitrates the single RAM port between the instruction cache and the data cache, one word transaction at a time. It sits between the icache/dcache memory-side signals and the RAM model, and drives the per-cache wait handshakes. The dcache has priority; a bounded starvation counter guarantees icache forward progress. Each grant is held until the RAM reports completion or the granted request drops.

## Interface
- STARVE_LIMIT, 4: consecutive dcache grants won while iREN pending before the icache is forced through (1..15)
- CLK  in  1  system clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- iREN  in  1  icache read request
- iaddr  in  32  icache word address
- iwait  out  1  low for exactly the completion cycle of an icache transaction
- iload  out  32  read data to icache (= ramload, combinational)
- dREN  in  1  dcache read request (block fill word)
- dWEN  in  1  dcache write request (write-back word); wins over dREN if both high
- daddr  in  32  dcache word address
- dstore  in  32  dcache write data
- dwait  out  1  low for exactly the completion cycle of a dcache transaction
- dload  out  32  read data to dcache (= ramload, combinational)
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
- err  out  1  sticky: set when ramstate==ERROR during a grant; cleared only by RST

## Operation
- States: IDLE, DGNT, IGNT. Registered state; all outputs combinational from state and inputs.
- IDLE: ramREN=ramWEN=0, ramaddr=0, ramstore=0, iwait=dwait=1. Arbitrate on current-cycle requests:
  - starve==STARVE_LIMIT and iREN -> IGNT.
  - else (dREN|dWEN) -> DGNT; if iREN also high, starve += 1 (saturating at STARVE_LIMIT).
  - else iREN -> IGNT.
  - else stay IDLE; starve reset to 0 when iREN low.
- Entering IGNT clears starve to 0.
- DGNT: ramWEN=dWEN, ramREN=dREN&~dWEN, ramaddr=daddr, ramstore=dstore; iwait=1. dwait=0 iff ramstate==ACCESS.
- IGNT: ramREN=iREN, ramWEN=0, ramaddr=iaddr, ramstore=0; dwait=1. iwait=0 iff ramstate==ACCESS.
- Grant exit to IDLE on: ramstate==ACCESS (completion); or granted request deasserted (abort; no wait pulse, strobes drop same cycle).
- ramstate FREE/BUSY: hold grant, wait high. ERROR: set err, hold grant, wait high (transaction retried until ACCESS or abort).
- Non-granted requester always sees wait=1; its request is never dropped, only delayed.
- iload and dload both equal ramload at all times; only the wait pulse qualifies validity.

## Timing
- RST high at an edge: state=IDLE, starve=0, err=0 next cycle, regardless of grant in progress; outputs then at IDLE values (ramREN=ramWEN=0, iwait=dwait=1). In-flight RAM access abandoned.
- Request seen in IDLE cycle t -> RAM strobes asserted cycle t+1. If ramstate==ACCESS in t+1, wait low in t+1 (2-cycle minimum per word).
- Completion cycle c -> IDLE in c+1 (one-cycle bubble, no strobes); next grant strobes at c+2 at earliest.
- Two-word dcache block fill with no contention and single-cycle RAM: words complete at t+1 and t+3.
- Simultaneous iREN and dREN in IDLE with starve<STARVE_LIMIT: dcache granted. With starve==STARVE_LIMIT: icache granted, starve->0.
- starve does not change while in DGNT/IGNT.

## Test plan
- Reset: hold RST 2 cycles during an active DGNT -> ramREN=ramWEN=0, dwait=iwait=1, err=0 next cycle; state IDLE.
- Single icache read, iaddr=0x40, RAM ACCESS on first strobe cycle, ramload=0xDEADBEEF -> ramREN=1 cycle t+1, iwait=0 in t+1 with iload=0xDEADBEEF, IDLE in t+2.
- dWEN and dREN both high, daddr=0x3100, dstore=0x12345678, RAM BUSY 3 cycles then ACCESS -> ramWEN=1, ramREN=0 for 4 cycles, dwait=0 only in 4th.
- iREN held, dcache requests continuously, STARVE_LIMIT=4 -> four dcache words complete, fifth grant goes to icache, starve back to 0.
- Granted icache drops iREN while RAM BUSY -> no iwait pulse, ramREN low same cycle, IDLE next cycle; pending dREN granted after.
- ramstate=ERROR for 2 cycles then ACCESS during DGNT -> err rises and stays 1, dwait=0 on the ACCESS cycle, err cleared only by RST.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Single-port RAM arbiter between the instruction and data caches.
// The dcache wins contention; a saturating starvation counter forces the icache through.
module cache_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DGNT = 2'd1;
    localparam logic [1:0] S_IGNT = 2'd2;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [1:0] r_state;
    logic [3:0] r_starve;
    logic       r_err;

    logic [1:0] w_next_state;
    logic [3:0] w_next_starve;
    logic       w_dreq;
    logic       w_done;
    logic       w_err_set;

    assign w_dreq    = dREN | dWEN;
    assign w_done    = (ramstate == RAM_ACCESS);
    assign w_err_set = ((r_state == S_DGNT) || (r_state == S_IGNT)) && (ramstate == RAM_ERROR);

    // Arbitration and grant-exit decisions; starvation count only moves in IDLE.
    always_comb begin
        w_next_state  = r_state;
        w_next_starve = r_starve;
        case (r_state)
            S_IDLE: begin
                if ((r_starve == LIMIT) && iREN) begin
                    w_next_state  = S_IGNT;
                    w_next_starve = 4'd0;
                end else if (w_dreq) begin
                    w_next_state = S_DGNT;
                    if (iREN && (r_starve < LIMIT)) begin
                        w_next_starve = r_starve + 4'd1;
                    end else begin
                        w_next_starve = r_starve;
                    end
                end else if (iREN) begin
                    w_next_state  = S_IGNT;
                    w_next_starve = 4'd0;
                end else begin
                    w_next_state  = S_IDLE;
                    w_next_starve = 4'd0;
                end
            end
            S_DGNT: begin
                if (!w_dreq || w_done) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_DGNT;
                end
            end
            S_IGNT: begin
                if (!iREN || w_done) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_IGNT;
                end
            end
            default: begin
                w_next_state  = S_IDLE;
                w_next_starve = 4'd0;
            end
        endcase
    end

    // State, starvation counter and sticky error flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_starve <= 4'd0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_starve <= w_next_starve;
            r_err    <= r_err | w_err_set;
        end
    end

    // RAM-side strobes and per-cache wait handshakes follow the current grant.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        case (r_state)
            S_DGNT: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = ~w_done;
            end
            S_IGNT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iwait   = ~w_done;
            end
            default: begin
                ramREN = 1'b0;
            end
        endcase
    end

    assign iload = ramload;
    assign dload = ramload;
    assign err   = r_err;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed, table-driven bench for cache_mem_arbiter plus starvation and abort sequences.
module tb_cache_mem_arbiter;

    localparam logic [1:0] FREE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] ACC  = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    typedef struct {
        logic        rst, iren, dren, dwen;
        logic [31:0] iaddr, daddr, dstore;
        logic [1:0]  rs;
        logic [31:0] rload;
        logic        e_ren, e_wen;
        logic [31:0] e_addr, e_store;
        logic        e_iwait, e_dwait, e_err;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST, iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vq[$];

    cache_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge and check the combinational outputs.
    task automatic step(input vec_t v, input string nm);
        @(negedge CLK);
        RST = v.rst; iREN = v.iren; dREN = v.dren; dWEN = v.dwen;
        iaddr = v.iaddr; daddr = v.daddr; dstore = v.dstore;
        ramstate = v.rs; ramload = v.rload;
        #1;
        chk({nm, " ctrl"}, {27'd0, ramREN, ramWEN, iwait, dwait, err},
            {27'd0, v.e_ren, v.e_wen, v.e_iwait, v.e_dwait, v.e_err});
        chk({nm, " addr"}, ramaddr, v.e_addr);
        chk({nm, " store"}, ramstore, v.e_store);
        chk({nm, " iload"}, iload, v.rload);
        chk({nm, " dload"}, dload, v.rload);
    endtask

    function automatic vec_t mk(
        input logic rst, iren, dren, dwen,
        input logic [31:0] ia, da, ds,
        input logic [1:0] rs, input logic [31:0] rl,
        input logic er, ew, input logic [31:0] ea, es,
        input logic eiw, edw, eerr);
        vec_t v;
        v.rst = rst; v.iren = iren; v.dren = dren; v.dwen = dwen;
        v.iaddr = ia; v.daddr = da; v.dstore = ds; v.rs = rs; v.rload = rl;
        v.e_ren = er; v.e_wen = ew; v.e_addr = ea; v.e_store = es;
        v.e_iwait = eiw; v.e_dwait = edw; v.e_err = eerr;
        return v;
    endfunction

    initial begin
        vec_t v;
        RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = 32'd0; daddr = 32'd0; dstore = 32'd0;
        ramload = 32'd0; ramstate = FREE;

        // idle, single icache read
        vq.push_back(mk(1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0,32'h0, FREE,32'h1111_1111, 1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,1'b0));
        vq.push_back(mk(1'b0,1'b1,1'b0,1'b0, 32'h40,32'h0,32'h0, FREE,32'h1111_1111, 1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,1'b0));
        vq.push_back(mk(1'b0,1'b1,1'b0,1'b0, 32'h40,32'h0,32'h0, ACC,32'hDEAD_BEEF, 1'b1,1'b0,32'h40,32'h0, 1'b0,1'b1,1'b0));
        vq.push_back(mk(1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0,32'h0, FREE,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,1'b0));
        // write wins over read, RAM busy 3 cycles then access
        vq.push_back(mk(1'b0,1'b0,1'b1,1'b1, 32'h0,32'h3100,32'h1234_5678, FREE,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,1'b0));
        for (int k = 0; k < 3; k++)
            vq.push_back(mk(1'b0,1'b0,1'b1,1'b1, 32'h0,32'h3100,32'h1234_5678, BUSY,32'h0, 1'b0,1'b1,32'h3100,32'h1234_5678, 1'b1,1'b1,1'b0));
        vq.push_back(mk(1'b0,1'b0,1'b1,1'b1, 32'h0,32'h3100,32'h1234_5678, ACC,32'h0, 1'b0,1'b1,32'h3100,32'h1234_5678, 1'b1,1'b0,1'b0));
        vq.push_back(mk(1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0,32'h0, FREE,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,1'b0));
        // two-word block fill: words complete two cycles apart
        vq.push_back(mk(1'b0,1'b0,1'b1,1'b0, 32'h0,32'h200,32'h0, FREE,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,1'b0));
        vq.push_back(mk(1'b0,1'b0,1'b1,1'b0, 32'h0,32'h200,32'h0, ACC,32'hCAFE_0001, 1'b1,1'b0,32'h200,32'h0, 1'b1,1'b0,1'b0));
        vq.push_back(mk(1'b0,1'b0,1'b1,1'b0, 32'h0,32'h204,32'h0, FREE,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,1'b0));
        vq.push_back(mk(1'b0,1'b0,1'b1,1'b0, 32'h0,32'h204,32'h0, ACC,32'hCAFE_0002, 1'b1,1'b0,32'h204,32'h0, 1'b1,1'b0,1'b0));
        // RAM error twice then access: err sticky
        vq.push_back(mk(1'b0,1'b0,1'b1,1'b0, 32'h0,32'h80,32'h0, FREE,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,1'b0));
        vq.push_back(mk(1'b0,1'b0,1'b1,1'b0, 32'h0,32'h80,32'h0, ERR,32'h0, 1'b1,1'b0,32'h80,32'h0, 1'b1,1'b1,1'b0));
        vq.push_back(mk(1'b0,1'b0,1'b1,1'b0, 32'h0,32'h80,32'h0, ERR,32'h0, 1'b1,1'b0,32'h80,32'h0, 1'b1,1'b1,1'b1));
        vq.push_back(mk(1'b0,1'b0,1'b1,1'b0, 32'h0,32'h80,32'h0, ACC,32'h0, 1'b1,1'b0,32'h80,32'h0, 1'b1,1'b0,1'b1));
        vq.push_back(mk(1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0,32'h0, FREE,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,1'b1));
        // reset held two cycles during an active dcache grant
        vq.push_back(mk(1'b0,1'b0,1'b1,1'b0, 32'h0,32'h300,32'h0, FREE,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,1'b1));
        vq.push_back(mk(1'b1,1'b0,1'b1,1'b0, 32'h0,32'h300,32'h0, BUSY,32'h0, 1'b1,1'b0,32'h300,32'h0, 1'b1,1'b1,1'b1));
        vq.push_back(mk(1'b1,1'b0,1'b1,1'b0, 32'h0,32'h300,32'h0, BUSY,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,1'b0));
        vq.push_back(mk(1'b0,1'b0,1'b1,1'b0, 32'h0,32'h300,32'h0, FREE,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,1'b0));
        vq.push_back(mk(1'b0,1'b0,1'b1,1'b0, 32'h0,32'h300,32'h0, ACC,32'h5555_AAAA, 1'b1,1'b0,32'h300,32'h0, 1'b1,1'b0,1'b0));
        vq.push_back(mk(1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0,32'h0, FREE,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,1'b0));

        repeat (3) @(negedge CLK);

        foreach (vq[i]) step(vq[i], $sformatf("vec%0d", i));

        // Starvation: four dcache words complete, then the icache is forced through.
        for (int k = 0; k < 12; k++) begin
            logic [31:0] rl;
            rl = 32'hC0DE_0000 | 32'(k);
            if ((k % 2) == 0)
                v = mk(1'b0,1'b1,1'b1,1'b0, 32'h1000,32'h2000,32'h0, ACC,rl, 1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,1'b0);
            else if (k == 9)
                v = mk(1'b0,1'b1,1'b1,1'b0, 32'h1000,32'h2000,32'h0, ACC,rl, 1'b1,1'b0,32'h1000,32'h0, 1'b0,1'b1,1'b0);
            else
                v = mk(1'b0,1'b1,1'b1,1'b0, 32'h1000,32'h2000,32'h0, ACC,rl, 1'b1,1'b0,32'h2000,32'h0, 1'b1,1'b0,1'b0);
            step(v, $sformatf("starve%0d", k));
        end

        // Abort: granted icache drops iREN while BUSY, pending dREN served after.
        step(mk(1'b0,1'b1,1'b0,1'b0, 32'h44,32'h0,32'h0, FREE,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,1'b0), "abort0");
        step(mk(1'b0,1'b1,1'b0,1'b0, 32'h44,32'h0,32'h0, BUSY,32'h0, 1'b1,1'b0,32'h44,32'h0, 1'b1,1'b1,1'b0), "abort1");
        step(mk(1'b0,1'b0,1'b1,1'b0, 32'h44,32'h500,32'h0, BUSY,32'h0, 1'b0,1'b0,32'h44,32'h0, 1'b1,1'b1,1'b0), "abort2");
        step(mk(1'b0,1'b0,1'b1,1'b0, 32'h44,32'h500,32'h0, FREE,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,1'b0), "abort3");
        step(mk(1'b0,1'b0,1'b1,1'b0, 32'h44,32'h500,32'h0, ACC,32'h7777_0000, 1'b1,1'b0,32'h500,32'h0, 1'b1,1'b0,1'b0), "abort4");
        step(mk(1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0,32'h0, FREE,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,1'b0), "abort5");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
